// File: rtl/sofa_plus_scan_pkg.sv
// Shared types and helpers for the sofa_plus scan-chain controller.
// Used by sofa_plus_scan_ctrl and sofa_plus_scan_shreg.
package sofa_plus_scan_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CAPTURE,
      S_UNLOAD,
      S_DONE
   } scan_state_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sofa_plus_scan_shreg.sv
// CHAIN_LEN-bit register with parallel load and MSB-first serial shift.
// Shifts toward the MSB, taking i_si into bit 0 and presenting bit WIDTH-1 on o_so.
module sofa_plus_scan_shreg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_shift,
   input  logic             i_si,
   output logic             o_so,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_data;
      end else if (i_shift) begin
         r_q <= {r_q[WIDTH-2:0], i_si};
      end
   end

   assign o_so = r_q[WIDTH-1];
   assign o_q  = r_q;

endmodule

// File: rtl/sofa_plus_scan_ctrl.sv
// Scan-chain controller: serial load, functional capture, serial unload into a result register.
// Optional result comparison is enabled by defining SOFA_PLUS_SCAN_CMP_EN.
module sofa_plus_scan_ctrl
   import sofa_plus_scan_pkg::*;
#(
   parameter int CHAIN_LEN      = 32,
   parameter int CAPTURE_CYCLES = 1
) (
   input  logic                                  C,
   input  logic                                  R,
   input  logic                                  start,
   input  logic [CHAIN_LEN-1:0]                  pattern_in,
   input  logic [CHAIN_LEN-1:0]                  expected_in,
   output logic                                  ready,
   output logic                                  scan_en,
   output logic                                  scan_di,
   input  logic                                  scan_do,
   output logic [CHAIN_LEN-1:0]                  result,
   output logic                                  result_valid,
   input  logic                                  result_ack,
   output logic                                  mismatch,
   output logic [cnt_width(CHAIN_LEN)-1:0]       mismatch_cnt
);

   localparam int MCNT_W = cnt_width(CHAIN_LEN);
   // Covers the longer of the shift phases and the capture phase.
   localparam int CNT_W  = cnt_width((CAPTURE_CYCLES > CHAIN_LEN) ? CAPTURE_CYCLES : CHAIN_LEN);

   scan_state_t        r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_scan_en;
   logic               r_scan_di;
   logic               r_result_valid;

   logic               w_accept;
   logic               w_pat_msb;
   logic [CHAIN_LEN-1:0] w_pat_q_unused;
   logic               w_res_so_unused;

   assign w_accept = (r_state == S_IDLE) && start;

   // The MSB goes straight to scan_di on the accepting edge; the rest queue up behind it.
   sofa_plus_scan_shreg #(.WIDTH(CHAIN_LEN)) u_pattern (
      .clk     (C),
      .rst     (R),
      .i_load  (w_accept),
      .i_data  ({pattern_in[CHAIN_LEN-2:0], 1'b0}),
      .i_shift (r_state == S_LOAD),
      .i_si    (1'b0),
      .o_so    (w_pat_msb),
      .o_q     (w_pat_q_unused)
   );

   sofa_plus_scan_shreg #(.WIDTH(CHAIN_LEN)) u_result (
      .clk     (C),
      .rst     (R),
      .i_load  (1'b0),
      .i_data  ('0),
      .i_shift (r_state == S_UNLOAD),
      .i_si    (scan_do),
      .o_so    (w_res_so_unused),
      .o_q     (result)
   );

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_ready        <= 1'b1;
         r_scan_en      <= 1'b0;
         r_scan_di      <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_LOAD;
                  r_cnt     <= CNT_W'(CHAIN_LEN - 1);
                  r_ready   <= 1'b0;
                  r_scan_en <= 1'b1;
                  r_scan_di <= pattern_in[CHAIN_LEN-1];
               end
            end
            S_LOAD: begin
               if (r_cnt == '0) begin
                  r_state   <= S_CAPTURE;
                  r_cnt     <= CNT_W'(CAPTURE_CYCLES - 1);
                  r_scan_en <= 1'b0;
                  r_scan_di <= 1'b0;
               end else begin
                  r_cnt     <= r_cnt - 1'b1;
                  r_scan_di <= w_pat_msb;
               end
            end
            S_CAPTURE: begin
               if (r_cnt == '0) begin
                  r_state   <= S_UNLOAD;
                  r_cnt     <= CNT_W'(CHAIN_LEN - 1);
                  r_scan_en <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_UNLOAD: begin
               if (r_cnt == '0) begin
                  r_state   <= S_DONE;
                  r_scan_en <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               // First DONE cycle settles the result (and comparison) before it is flagged valid.
               if (!r_result_valid) begin
                  r_result_valid <= 1'b1;
               end else if (result_ack) begin
                  r_state        <= S_IDLE;
                  r_result_valid <= 1'b0;
                  r_ready        <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_ready   <= 1'b1;
               r_scan_en <= 1'b0;
               r_scan_di <= 1'b0;
            end
         endcase
      end
   end

   assign ready        = r_ready;
   assign scan_en      = r_scan_en;
   assign scan_di      = r_scan_di;
   assign result_valid = r_result_valid;

`ifdef SOFA_PLUS_SCAN_CMP_EN
   logic [CHAIN_LEN-1:0] r_expected;
   logic                 r_mismatch;
   logic [MCNT_W-1:0]    r_mismatch_cnt;
   logic [CHAIN_LEN-1:0] w_diff;
   logic [MCNT_W-1:0]    w_popcnt;

   assign w_diff = result ^ r_expected;

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         w_popcnt = w_popcnt + MCNT_W'(w_diff[i]);
      end
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         r_expected     <= '0;
         r_mismatch     <= 1'b0;
         r_mismatch_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_expected <= expected_in;
         end
         if ((r_state == S_DONE) && !r_result_valid) begin
            r_mismatch     <= |w_diff;
            r_mismatch_cnt <= w_popcnt;
         end
      end
   end

   assign mismatch     = r_mismatch;
   assign mismatch_cnt = r_mismatch_cnt;
`else
   logic w_expected_unused;
   assign w_expected_unused = ^expected_in;
   assign mismatch          = 1'b0;
   assign mismatch_cnt      = '0;
`endif

endmodule
